// File: rtl/ime_sad_32x32_min.sv
// ime_sad_32x32_min
// Merges four-lane 16x16 SADs (blocks 0..3) into 32x32 SADs and tracks the
// minimum over one search sweep. Three-stage pipeline:
//   S1 lane sums, S2 lane-minimum tree, S3 running-best compare.
// Optional macro IME_SAD_32X32_MIN_16X16_EN adds per-block (16x16) best
// tracking outputs best16_sad_o / best16_addr_o / best16_lane_o.
module ime_sad_32x32_min #(
   parameter int SAD_W  = 16,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  val_i,
   input  logic                  last_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [4*SAD_W-1:0]    sad_0x_i,
   input  logic [4*SAD_W-1:0]    sad_1x_i,
   input  logic [4*SAD_W-1:0]    sad_2x_i,
   input  logic [4*SAD_W-1:0]    sad_3x_i,
`ifdef IME_SAD_32X32_MIN_16X16_EN
   output logic [4*SAD_W-1:0]    best16_sad_o,
   output logic [4*ADDR_W-1:0]   best16_addr_o,
   output logic [7:0]            best16_lane_o,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   output logic [SAD_W+1:0]      best_sad_o,
   output logic [ADDR_W-1:0]     best_addr_o,
   output logic [1:0]            best_lane_o
);

   localparam int SUM_W = SAD_W + 2;

   // Four-way minimum returning {lane, value}; ties resolve to the lower lane.
   function automatic logic [SUM_W+1:0] pick_min_sum(input logic [SUM_W-1:0] a0,
                                                     input logic [SUM_W-1:0] a1,
                                                     input logic [SUM_W-1:0] a2,
                                                     input logic [SUM_W-1:0] a3);
      logic [SUM_W-1:0] m01;
      logic [SUM_W-1:0] m23;
      logic             l01;
      logic             l23;
      l01 = (a1 < a0);
      m01 = l01 ? a1 : a0;
      l23 = (a3 < a2);
      m23 = l23 ? a3 : a2;
      if (m23 < m01) pick_min_sum = {1'b1, l23, m23};
      else           pick_min_sum = {1'b0, l01, m01};
   endfunction

   logic                accept;
   logic [SUM_W-1:0]    lane_sum [4];

   logic                s1_val;
   logic                s1_last;
   logic [ADDR_W-1:0]   s1_addr;
   logic [SUM_W-1:0]    s1_sum [4];
   logic [SUM_W+1:0]    s1_pick;

   logic                s2_val;
   logic                s2_last;
   logic [ADDR_W-1:0]   s2_addr;
   logic [SUM_W-1:0]    s2_min;
   logic [1:0]          s2_lane;

   assign accept = val_i & (busy_o | start_i);

   // Per-lane 32x32 SAD: zero-extended sum of the four block SADs (lane0 in MSBs).
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane_sum[k] = SUM_W'(sad_0x_i[(3-k)*SAD_W +: SAD_W])
                     + SUM_W'(sad_1x_i[(3-k)*SAD_W +: SAD_W])
                     + SUM_W'(sad_2x_i[(3-k)*SAD_W +: SAD_W])
                     + SUM_W'(sad_3x_i[(3-k)*SAD_W +: SAD_W]);
      end
   end

   // S1: register accepted rows with their lane sums, address and last flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_val  <= 1'b0;
         s1_last <= 1'b0;
         s1_addr <= '0;
         for (int k = 0; k < 4; k++) s1_sum[k] <= '0;
      end else begin
         s1_val  <= accept;
         s1_last <= val_i & last_i;
         s1_addr <= addr_i;
         for (int k = 0; k < 4; k++) s1_sum[k] <= lane_sum[k];
      end
   end

   assign s1_pick = pick_min_sum(s1_sum[0], s1_sum[1], s1_sum[2], s1_sum[3]);

   // S2: lane minimum; a start flushes whatever S1 held from the old search.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_val  <= 1'b0;
         s2_last <= 1'b0;
         s2_addr <= '0;
         s2_min  <= '0;
         s2_lane <= '0;
      end else begin
         s2_val  <= s1_val & ~start_i;
         s2_last <= s1_last;
         s2_addr <= s1_addr;
         s2_min  <= s1_pick[SUM_W-1:0];
         s2_lane <= s1_pick[SUM_W+1:SUM_W];
      end
   end

   // S3: running best (strict less-than keeps the earliest), busy and done control.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         best_sad_o  <= '1;
         best_addr_o <= '0;
         best_lane_o <= '0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            busy_o      <= 1'b1;
            best_sad_o  <= '1;
            best_addr_o <= '0;
            best_lane_o <= '0;
         end else if (s2_val) begin
            if (s2_min < best_sad_o) begin
               best_sad_o  <= s2_min;
               best_addr_o <= s2_addr;
               best_lane_o <= s2_lane;
            end
            if (s2_last) begin
               done_o <= 1'b1;
               busy_o <= 1'b0;
            end
         end
      end
   end

`ifdef IME_SAD_32X32_MIN_16X16_EN
   // Four-way minimum of one block's lanes, {lane, value}; ties to the lower lane.
   function automatic logic [SAD_W+1:0] pick_min_blk(input logic [4*SAD_W-1:0] lanes);
      logic [SAD_W-1:0] a0, a1, a2, a3, m01, m23;
      logic             l01, l23;
      a0  = lanes[3*SAD_W +: SAD_W];
      a1  = lanes[2*SAD_W +: SAD_W];
      a2  = lanes[1*SAD_W +: SAD_W];
      a3  = lanes[0 +: SAD_W];
      l01 = (a1 < a0);
      m01 = l01 ? a1 : a0;
      l23 = (a3 < a2);
      m23 = l23 ? a3 : a2;
      if (m23 < m01) pick_min_blk = {1'b1, l23, m23};
      else           pick_min_blk = {1'b0, l01, m01};
   endfunction

   logic [4*SAD_W-1:0] s1_blk      [4];
   logic [SAD_W+1:0]   blk_pick    [4];
   logic [SAD_W-1:0]   s2_blk_min  [4];
   logic [1:0]         s2_blk_lane [4];

   // S1 copy of the raw block SADs for per-block tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) s1_blk[b] <= '0;
      end else begin
         s1_blk[0] <= sad_0x_i;
         s1_blk[1] <= sad_1x_i;
         s1_blk[2] <= sad_2x_i;
         s1_blk[3] <= sad_3x_i;
      end
   end

   // Lane minimum of each block.
   always_comb begin
      for (int b = 0; b < 4; b++) blk_pick[b] = pick_min_blk(s1_blk[b]);
   end

   // S2 per-block lane minimum registers; validity shared with the main path.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            s2_blk_min[b]  <= '0;
            s2_blk_lane[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            s2_blk_min[b]  <= blk_pick[b][SAD_W-1:0];
            s2_blk_lane[b] <= blk_pick[b][SAD_W+1:SAD_W];
         end
      end
   end

   // S3 per-block running best, block0 packed in the MSBs.
   always_ff @(posedge clk) begin
      if (rst) begin
         best16_sad_o  <= '1;
         best16_addr_o <= '0;
         best16_lane_o <= '0;
      end else if (start_i) begin
         best16_sad_o  <= '1;
         best16_addr_o <= '0;
         best16_lane_o <= '0;
      end else if (s2_val) begin
         for (int b = 0; b < 4; b++) begin
            if (s2_blk_min[b] < best16_sad_o[(3-b)*SAD_W +: SAD_W]) begin
               best16_sad_o[(3-b)*SAD_W +: SAD_W]   <= s2_blk_min[b];
               best16_addr_o[(3-b)*ADDR_W +: ADDR_W] <= s2_addr;
               best16_lane_o[(3-b)*2 +: 2]           <= s2_blk_lane[b];
            end
         end
      end
   end
`endif

endmodule

// File: doc/ime_sad_32x32_min.md
Name: ime_sad_32x32_min

Overview:
- Consumes the four-lane 16x16 SAD words read back from the 16x16 SAD buffer (blocks 0..2) together with the live block-3 SADs from the SAD array.
- Merges the four 16x16 SADs per lane into a 32x32 SAD, then tracks the minimum over a full search sweep.
- Sits directly downstream of the 16x16 SAD buffer, feeding the IME decision/MV output stage.
- Reports the best SAD, the candidate row address and the lane of each search, with a done pulse.

Parameters:
- SAD_W, 16, width of one 16x16 SAD (PIXEL_WIDTH+8)
- ADDR_W, 5, width of the candidate row address (buffer depth 32)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start_i  input  1  begin new search; clears running best and flushes pipeline
- val_i  input  1  inputs below carry a valid candidate row this cycle
- last_i  input  1  qualified by val_i; final row of the sweep
- addr_i  input  ADDR_W  row address of the candidate, aligned with the data
- sad_0x_i  input  4*SAD_W  block-0 SADs; lane0 in MSBs, lane3 in LSBs
- sad_1x_i  input  4*SAD_W  block-1 SADs, same packing
- sad_2x_i  input  4*SAD_W  block-2 SADs, same packing
- sad_3x_i  input  4*SAD_W  block-3 (live) SADs, same packing
- busy_o  output  1  search in progress
- done_o  output  1  one-cycle pulse; best_* final
- best_sad_o  output  SAD_W+2  minimum 32x32 SAD
- best_addr_o  output  ADDR_W  row of minimum
- best_lane_o  output  2  lane of minimum

Behaviour:
- Reset (rst=1 at edge): busy_o=0, done_o=0, best_sad_o=all ones, best_addr_o=0, best_lane_o=0. All pipeline valid bits are cleared.
- Three-stage pipeline. Any val_i accepted while busy_o=1, or in the start_i cycle, enters S1.
- S1 registers four lane sums: sum_k = b0_k + b1_k + b2_k + b3_k.
  - Zero-extended to SAD_W+2 bits; no saturation is needed.
  - addr and last are registered alongside.
- S2 selects the lane minimum with a comparator tree. Ties go to the lower lane index; registers {lane_min, lane, addr, last}.
- S3 compares lane_min against the running best.
  - Update only on strict less-than, so the earliest candidate wins ties.
- Latency: a row sampled with last_i at edge T produces done_o=1 in cycle T+3. best_* already includes that row in that cycle.
- done_o lasts exactly one cycle; busy_o falls in the same cycle done_o rises. best_* hold until the next start_i or rst.
- start_i:
  - Sets busy_o=1 from the next cycle.
  - Sets best_sad_o to all ones and best_addr_o/best_lane_o to 0.
  - Clears S1-S3 valid bits, discarding in-flight rows of any earlier search; no done_o is produced for the aborted search.
  - A val_i presented together with start_i is accepted as the first row of the new search.
- val_i while busy_o=0 and start_i=0 is ignored.
- last_i without val_i is ignored.
- A start_i arriving in the same cycle an in-flight last reaches S3 aborts that search; done_o is suppressed.
- A sweep of a single row with val_i & last_i & start_i together is legal; done_o arrives 3 cycles later.
- rst mid-search discards everything; no done_o is produced.
- A valid candidate with SAD all ones never updates best; best_addr_o/best_lane_o stay 0.

Optional Feature:
- Macro: IME_SAD_32X32_MIN_16X16_EN.
- Defined:
  - Adds outputs best16_sad_o (4*SAD_W), best16_addr_o (4*ADDR_W) and best16_lane_o (4*2), packed block0 in MSBs.
  - Each block is tracked independently through the same S2/S3 rules: lane tie to lower lane, strict less-than across rows.
  - Values are valid when done_o=1; reset values are all ones / 0 / 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then val_i=1 without start_i → busy_o=0, done_o never asserts, best_sad_o=0x3FFFF.
- Single row: start_i+val_i+last_i, addr=5, block SADs per lane {10,20,30,40} all blocks → done_o at T+3, best_sad_o=40, best_addr_o=5, best_lane_o=0.
- Sweep of 32 rows, row r lane k all blocks = 100+r+k, except row 17 lane 2 = 3 → best_sad_o=12, addr=17, lane=2, done_o once.
- Ties: rows 3 and 9 both give 32x32 SAD 50 in lanes 1 and 0 → best_addr_o=3, best_lane_o=1.
- Abort: start_i again while row 31 with last_i is in S2 → no done_o for the first search; the second search reports its own result.
- Feature on: block-1 minimum 7 at row 4 lane 3, other blocks minimal at row 0 lane 0 → best16 block1 = {7, 4, 3}, others = row 0 lane 0.
